fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS fetch stage, one outstanding imem request, next-PC select on instr_done.
// Define FETCH_ALIGN_CHECK_EN to halt with a sticky misalign flag on an unaligned next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        branch,
    input  logic        j,
    input  logic        zero,
    output logic        misalign
);
`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;
`else
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
`endif
    state_t state, state_n;
    logic [31:0] npc_sel, npc;
    logic bad;
    assign pc_plus4 = pc + 32'd4;
    assign imem_req_addr = pc;
    // reset gates the request so none is seen while reset is held
    assign imem_req_valid = (state == REQ) && !reset;
    assign instr_valid = (state == HOLD);
    always_comb begin
        npc_sel = j ? {pc_plus4[31:28], instr[25:0], 2'b00}
                : (branch && zero) ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
                : pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
        bad = |npc_sel[1:0];
        npc = npc_sel;
`else
        bad = 1'b0;
        npc = npc_sel & ~32'd3;
`endif
        state_n = state;
        case (state)
            REQ:     state_n = imem_req_ready ? WAIT : REQ;
            WAIT:    state_n = imem_rsp_valid ? HOLD : WAIT;
`ifdef FETCH_ALIGN_CHECK_EN
            HOLD:    state_n = !instr_done ? HOLD : bad ? HALT : REQ;
`else
            HOLD:    state_n = instr_done ? REQ : HOLD;
`endif
            default: state_n = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
            instr <= 32'd0;
        end else begin
            state <= state_n;
            if (state == WAIT && imem_rsp_valid) instr <= imem_rsp_data;
            if (state == HOLD && instr_done && !bad) pc <= npc;
        end
    end
`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) misalign <= 1'b0;
        else if (state == HOLD && instr_done && bad) misalign <= 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized fetches against a next-PC reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        instr_valid;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_done = 1'b0;
    logic        branch = 1'b0;
    logic        j = 1'b0;
    logic        zero = 1'b0;
    logic        misalign;

    int passed = 0;
    int total = 0;
    logic [31:0] exp_pc;

    fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
        .pc(pc), .pc_plus4(pc_plus4), .instr_done(instr_done), .branch(branch),
        .j(j), .zero(zero), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        b, jj, z;
        logic [31:0] nxt;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Next PC from the MIPS rules in plain arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic b, input logic jj, input logic z);
        logic [31:0] s;
        int off;
        s = p + 32'd4;
        off = int'(signed'(w[15:0]));
        if (jj) return (s & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (b && z) return s + 32'(off * 4);
        return s;
    endfunction

    // One instruction: request, optional stalls, response, hold, completion
    task automatic fetch_one(input logic [31:0] word, input logic b, input logic jj, input logic z,
                             input int rdy_d, input int rsp_d, input int done_d);
        chk1("req_valid", imem_req_valid, 1'b1);
        chk("req_addr", imem_req_addr, exp_pc);
        for (int k = 0; k < rdy_d; k++) begin
            imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = ~word;
            instr_done = 1'b1; j = 1'b1;
            @(negedge clk);
            chk("stall_addr", imem_req_addr, exp_pc);
            chk1("stall_ivalid", instr_valid, 1'b0);
        end
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = ~word;
        instr_done = 1'b0; j = 1'b0;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk1("wait_req_valid", imem_req_valid, 1'b0);
        for (int k = 0; k < rsp_d; k++) begin
            imem_rsp_valid = 1'b0; instr_done = 1'b1;
            @(negedge clk);
            chk1("wait_ivalid", instr_valid, 1'b0);
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = word; instr_done = 1'b0;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk1("hold_ivalid", instr_valid, 1'b1);
        chk("hold_instr", instr, word);
        chk("hold_pc", pc, exp_pc);
        chk("hold_pc4", pc_plus4, exp_pc + 32'd4);
        for (int k = 0; k < done_d; k++) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = ~word;
            branch = 1'b1; j = 1'b1; zero = 1'b1;
            @(negedge clk);
            chk("hold_stable_instr", instr, word);
            chk1("hold_stable_ivalid", instr_valid, 1'b1);
        end
        imem_rsp_valid = 1'b0; instr_done = 1'b1; branch = b; j = jj; zero = z;
        @(negedge clk);
        instr_done = 1'b0; branch = 1'b0; j = 1'b0; zero = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0044};
        tbl[1]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0048};
        tbl[2]  = '{32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        tbl[3]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_00FC};
        tbl[4]  = '{32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        tbl[5]  = '{32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 32'h0000_0104};
        tbl[6]  = '{32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};
        tbl[7]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h1000_0000};
        tbl[8]  = '{32'h0800_0010, 1'b0, 1'b1, 1'b0, 32'h1000_0040};
        tbl[9]  = '{32'h0800_0100, 1'b1, 1'b1, 1'b1, 32'h1000_0400};
        tbl[10] = '{32'h1000_FFEE, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

        @(negedge clk);
        @(negedge clk);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_ivalid", instr_valid, 1'b0);
        chk("rst_pc", pc, 32'h0000_0040);
        chk("rst_instr", instr, 32'd0);
        chk1("rst_misalign", misalign, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        exp_pc = 32'h0000_0040;

        for (int i = 0; i < 10; i++) begin
            fetch_one(tbl[i].word, tbl[i].b, tbl[i].jj, tbl[i].z, (i == 1) ? 3 : 0, 0, 0);
            exp_pc = tbl[i].nxt;
        end

        // Reset while WAIT; the late response must be dropped
        chk("pre_rst_addr", imem_req_addr, exp_pc);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk1("midrst_req_valid", imem_req_valid, 1'b0);
        chk1("midrst_ivalid", instr_valid, 1'b0);
        reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk1("postrst_ivalid", instr_valid, 1'b0);
        chk("postrst_instr", instr, 32'd0);
        exp_pc = 32'h0000_0040;

        for (int i = 10; i < 12; i++) begin
            fetch_one(tbl[i].word, tbl[i].b, tbl[i].jj, tbl[i].z, 0, 1, 1);
            exp_pc = tbl[i].nxt;
        end

        for (int i = 0; i < 200; i++) begin
            logic [31:0] w;
            logic rb, rj, rz;
            w = $urandom;
            rb = 1'($urandom_range(0, 1));
            rj = 1'($urandom_range(0, 1));
            rz = 1'($urandom_range(0, 1));
            fetch_one(w, rb, rj, rz, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            exp_pc = model_next(exp_pc, w, rb, rj, rz);
        end
        chk("final_addr", imem_req_addr, exp_pc);
        chk1("final_misalign", misalign, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
